traffic_light_timed: RTL and testbench
======================================

Name: traffic_light_timed

Overview:
- Parametrised two-road intersection controller (road A, road B); the timed successor of the basic sensor-driven traffic light FSM.
- Adds per-phase cycle timers (min/max green, yellow, all-red clearance), anti-starvation max-out, and a flashing-yellow maintenance mode.
- Sits directly between the road sensor inputs and the lamp drivers; Moore outputs decoded from the state register.

Parameters:
- CNT_W, 16, phase timer width in bits; all time parameters must fit in CNT_W bits.
- MIN_GREEN, 4, minimum green duration in clk cycles; must be >= 1.
- MAX_GREEN, 10, green duration after which a waiting cross road forces a change; must be >= MIN_GREEN.
- YELLOW_TIME, 2, yellow duration in cycles; must be >= 1.
- ALL_RED_TIME, 1, all-red clearance duration in cycles; must be >= 1.
- FLASH_HALF, 3, half-period in cycles of the flash blink; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- T_A  in  1  traffic present on road A (synchronous, level).
- T_B  in  1  traffic present on road B (synchronous, level).
- flash_mode  in  1  maintenance request: flashing yellow on both roads while high.
- L_A  out  2  road A lamp: 00 green, 01 yellow, 11 red, 10 off.
- L_B  out  2  road B lamp, same encoding.
- state  out  3  current state code (debug/observability).

Behaviour:
- One clock; reset is asynchronous and active-low. Reset forces state=A_GREEN (0), timer=0, blink phase=on; hence L_A=00, L_B=11, state=000 during and right after reset. Reset mid-phase aborts the phase immediately.
- States/codes: A_GREEN 0, A_YELLOW 1, A_CLR 2, B_GREEN 3, B_YELLOW 4, B_CLR 5, FLASH 6. Code 7 is illegal.
- Lamps: A_GREEN A=00/B=11; A_YELLOW A=01/B=11; A_CLR, B_CLR both 11; B_GREEN A=11/B=00; B_YELLOW A=11/B=01; FLASH both 01 when blink on, both 10 when off; code 7 both 11.
- Timer: counts cycles spent in current state; cleared to 0 on the clock edge where next state != state; otherwise increments, saturating at all-ones.
- A_GREEN: leave to A_YELLOW when timer >= MIN_GREEN-1 AND (T_A==0 OR (T_B==1 AND timer >= MAX_GREEN-1)). With T_A=1 and T_B=0, holds green indefinitely.
- A_YELLOW -> A_CLR when timer == YELLOW_TIME-1. A_CLR -> B_GREEN when timer == ALL_RED_TIME-1.
- B_GREEN/B_YELLOW/B_CLR: mirror of A with T_A/T_B swapped; B_CLR -> A_GREEN.
- Result: green lasts >= MIN_GREEN cycles, yellow exactly YELLOW_TIME, clearance exactly ALL_RED_TIME.
- flash_mode==1 sampled in any non-FLASH state: next state FLASH (overrides all timer conditions, including mid-yellow).
- FLASH: blink phase starts on at entry; toggles when timer == FLASH_HALF-1 (timer cleared on toggle). flash_mode==0 sampled: next state B_CLR (all-red clearance, then A_GREEN).
- Illegal code 7: next state B_CLR.
- T_A, T_B, flash_mode are assumed already synchronised; no internal synchronisers.

Test Plan:
- Reset with T_A=1,T_B=0 held 30 cycles -> state stays 0, L_A=00, L_B=11 throughout; assert reset_n low mid-B_GREEN -> L_A=00, L_B=11 asynchronously.
- T_A=0,T_B=1 from reset -> A_GREEN exactly 4 cycles, A_YELLOW 2 (L_A=01), A_CLR 1 (both 11), then B_GREEN (L_B=00, state=3).
- T_A=1,T_B=1 constant -> A_GREEN lasts exactly 10 cycles (max-out), then yellow 2, clear 1, B_GREEN lasts 10, and the cycle repeats with period 26.
- T_A drops at cycle 1 of A_GREEN -> green still held until timer=3 (MIN_GREEN), then A_YELLOW.
- flash_mode raised during A_YELLOW -> next cycle state=6, lamps 01/01 for 3 cycles, 10/10 for 3, repeat; drop flash_mode -> state 5 (both 11) 1 cycle, then state 0.
- Force state register to 7 (bench deposit) -> lamps 11/11, next cycle state=5, then 0.

Source files
------------

// File: rtl/traffic_light_timed.sv
// traffic_light_timed: timed two-road intersection controller with max-out and flashing-yellow maintenance
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   T_A, T_B   - traffic present on road A / road B (already synchronised, level)
//   flash_mode - maintenance request, flashing yellow on both roads while high
//   L_A, L_B   - lamp drives: 00 green, 01 yellow, 11 red, 10 off
//   state      - current state code
module traffic_light_timed #(
    parameter int CNT_W        = 16,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 10,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int FLASH_HALF   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       T_A,
    input  logic       T_B,
    input  logic       flash_mode,
    output logic [1:0] L_A,
    output logic [1:0] L_B,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_CLR    = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_CLR    = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] CLR_M1 = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] FLS_M1 = CNT_W'(FLASH_HALF - 1);

    // Plain vector so the illegal code 7 is representable in the register.
    logic [2:0]       state_q;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] timer;
    logic             blink;
    logic             flash_toggle;

    assign state        = state_q;
    assign flash_toggle = (state_q == FLASH) && (timer == FLS_M1);

    always_comb begin
        next_state = state_q;
        if (flash_mode && state_q != FLASH) begin
            next_state = FLASH;
        end else begin
            case (state_q)
                A_GREEN:  if (timer >= MIN_M1 && (!T_A || (T_B && timer >= MAX_M1))) next_state = A_YELLOW;
                A_YELLOW: if (timer == YEL_M1) next_state = A_CLR;
                A_CLR:    if (timer == CLR_M1) next_state = B_GREEN;
                B_GREEN:  if (timer >= MIN_M1 && (!T_B || (T_A && timer >= MAX_M1))) next_state = B_YELLOW;
                B_YELLOW: if (timer == YEL_M1) next_state = B_CLR;
                B_CLR:    if (timer == CLR_M1) next_state = A_GREEN;
                FLASH:    if (!flash_mode) next_state = B_CLR;
                default:  next_state = B_CLR;
            endcase
        end
    end

    always_comb begin
        L_A = 2'b11;
        L_B = 2'b11;
        case (state_q)
            A_GREEN:  L_A = 2'b00;
            A_YELLOW: L_A = 2'b01;
            B_GREEN:  L_B = 2'b00;
            B_YELLOW: L_B = 2'b01;
            FLASH: begin
                L_A = blink ? 2'b01 : 2'b10;
                L_B = blink ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

    // Blink restarts "on" whenever FLASH is entered; it only toggles while FLASH is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= A_GREEN;
            timer   <= '0;
            blink   <= 1'b1;
        end else begin
            state_q <= next_state;
            timer   <= (next_state != state_q || flash_toggle) ? '0 : (timer == '1 ? timer : timer + 1'b1);
            blink   <= (state_q != FLASH || next_state != FLASH) ? 1'b1 : blink ^ flash_toggle;
        end
    end
endmodule

// File: tb/tb_traffic_light_timed.sv
// tb_traffic_light_timed: directed self-checking bench for traffic_light_timed
module tb_traffic_light_timed;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       T_A;
    logic       T_B;
    logic       flash_mode;
    logic [1:0] L_A;
    logic [1:0] L_B;
    logic [2:0] state;
    int         compared = 0;
    int         mismatched = 0;

    traffic_light_timed dut (
        .clk(clk),
        .reset_n(reset_n),
        .T_A(T_A),
        .T_B(T_B),
        .flash_mode(flash_mode),
        .L_A(L_A),
        .L_B(L_B),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] s, input logic [1:0] a, input logic [1:0] b);
        compared++;
        assert ({state, L_A, L_B} === {s, a, b})
        else begin
            mismatched++;
            $error("FAIL %s: observed state=%0d L_A=%b L_B=%b, expected state=%0d L_A=%b L_B=%b",
                   tag, state, L_A, L_B, s, a, b);
        end
    endtask

    task automatic chk_s(input string tag, input logic [2:0] s);
        compared++;
        assert (state === s)
        else begin
            mismatched++;
            $error("FAIL %s: observed state=%0d, expected state=%0d", tag, state, s);
        end
    endtask

    // Hold reset for two cycles with the given traffic, release on a falling edge.
    task automatic restart(input logic ta, input logic tb);
        reset_n = 1'b0;
        T_A = ta;
        T_B = tb;
        flash_mode = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        T_A = 1'b1;
        T_B = 1'b0;
        flash_mode = 1'b0;
        #1 chk("reset_asserted", 3'd0, 2'b00, 2'b11);
        @(negedge clk);
        chk("reset_held", 3'd0, 2'b00, 2'b11);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk("a_hold", 3'd0, 2'b00, 2'b11);
            @(negedge clk);
        end

        restart(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("min_green", 3'd0, 2'b00, 2'b11);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            chk("a_yellow", 3'd1, 2'b01, 2'b11);
            @(negedge clk);
        end
        chk("a_clr", 3'd2, 2'b11, 2'b11);
        @(negedge clk);
        chk("b_green", 3'd3, 2'b11, 2'b00);
        @(negedge clk);
        chk("b_green_hold", 3'd3, 2'b11, 2'b00);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 3'd0, 2'b00, 2'b11);

        restart(1'b1, 1'b1);
        for (int k = 0; k < 52; k++) begin
            automatic int p = k % 26;
            chk_s("max_out", p < 10 ? 3'd0 : p < 12 ? 3'd1 : p < 13 ? 3'd2 : p < 23 ? 3'd3 : p < 25 ? 3'd4 : 3'd5);
            @(negedge clk);
        end

        restart(1'b1, 1'b0);
        @(negedge clk);
        T_A = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("min_after_drop", 3'd0, 2'b00, 2'b11);
            @(negedge clk);
        end
        chk("yellow_after_drop", 3'd1, 2'b01, 2'b11);
        flash_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if ((i / 3) % 2 == 0) chk("flash_on", 3'd6, 2'b01, 2'b01);
            else chk("flash_off", 3'd6, 2'b10, 2'b10);
            @(negedge clk);
        end
        flash_mode = 1'b0;
        @(negedge clk);
        chk("flash_exit_clr", 3'd5, 2'b11, 2'b11);
        @(negedge clk);
        chk("flash_exit_green", 3'd0, 2'b00, 2'b11);

        dut.state_q = 3'd7;
        #1 chk("illegal_lamps", 3'd7, 2'b11, 2'b11);
        @(negedge clk);
        chk("illegal_recover", 3'd5, 2'b11, 2'b11);
        @(negedge clk);
        chk("illegal_to_green", 3'd0, 2'b00, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
